// File: rtl/irq_tx_fifo.sv
// irq_tx_fifo: 16-entry tx interrupt queue; config bus push/status/flush in, tx valid/ready out, registered rdata/error back
module irq_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [13:0]       config_addr,
  input  logic              config_en,
  input  logic              config_wr,
  input  logic [31:0]       config_wdata,
  input  logic              sel,
  output logic [31:0]       config_slv_rdata,
  output logic              config_slv_error,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_kind,
  output logic [DATA_W-1:0] tx_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [DATA_W:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [10:0] addr;
  logic access, full, empty, push, push_ok, pop, stat_rd, legal, flush;
  logic unused_bits;
  assign unused_bits = ^{config_addr[13:11], config_wdata[31:DATA_W]};
  always_comb begin
    addr = config_addr[10:0];
    access = sel & config_en;
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    push = access & config_wr & (addr == 11'd0 | addr == 11'd1);
    stat_rd = access & !config_wr & addr == 11'd2;
    legal = push | stat_rd | (access & config_wr & addr == 11'd3);
    flush = access & config_wr & addr == 11'd3 & config_wdata[0];
    push_ok = push & !full;
    pop = !empty & tx_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(push_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
    count_d = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
    ovf_d = (push & full) | (ovf_q & !stat_rd);
    err_d = (access & !legal) | (push & full);
    rdata_d = stat_rd ? 32'({ovf_q, full, empty, 2'b00, count_q}) : '0;
    tx_valid = !empty;
    tx_kind = !empty & mem_q[rd_ptr_q][DATA_W];
    tx_data = empty ? '0 : mem_q[rd_ptr_q][DATA_W-1:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= {addr[0], config_wdata[DATA_W-1:0]};
  assign config_slv_rdata = rdata_q;
  assign config_slv_error = err_q;
endmodule
